// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive sampler:
//   - rx_state_t : sampler FSM states (IDLE, START_CHK, BIT)
//   - OSR        : oversample strobes per bit (fixed at 16)
//   - VOTE_LO/MID/HI : oversample indices whose samples feed the bit vote
//   - FRAME_TICKS: ticks per frame (start + 8 data + stop)
//   - STOP_IDX   : bit counter value while sampling the stop bit
//   - majority3(): 2-of-3 majority helper
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_CHK = 2'd1,
    BIT       = 2'd2
  } rx_state_t;

  localparam int OSR = 16;

  localparam logic [3:0] VOTE_LO  = 4'd7;
  localparam logic [3:0] VOTE_MID = 4'd8;
  localparam logic [3:0] VOTE_HI  = 4'd9;

  localparam int FRAME_TICKS = 10;

  // In BIT the counter runs 0..7 for data and reaches FRAME_TICKS-2 on the
  // stop bit, after which the sampler releases the line.
  localparam logic [3:0] STOP_IDX = 4'(FRAME_TICKS - 2);

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen
//   Oversample prescaler. Counts 0..CLKS_PER_SAMPLE-1 and wraps; strobe is
//   high while the count sits at its terminal value. A synchronous clear
//   forces the count back to 0 so the strobe phase can be anchored to an
//   external event (the start edge).
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-low reset
//   clr    in  synchronous clear of the count
//   strobe out one-clk pulse every CLKS_PER_SAMPLE clks
module uart_baud_gen #(
  parameter int CLKS_PER_SAMPLE = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic strobe
);

  localparam int CW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_SAMPLE - 1);

  logic [CW-1:0] cnt_reg;

  assign strobe = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr || strobe) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler
//   Receive front end for the UART receiver FSM. Synchronises the serial
//   pin, detects the start-bit falling edge, oversamples each bit OSR times
//   and emits one rx_tick per bit centre with the sampled bit on rx_in.
//   Every accepted frame yields exactly FRAME_TICKS ticks (start, 8 data,
//   stop); the sampler goes back to IDLE at mid-stop-bit so a following
//   start edge is never missed.
//
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   rx_en     in  sampler enable; low forces IDLE and suppresses ticks
//   rx_pin    in  raw asynchronous serial line, idle high
//   rx_in     out registered bit value, valid with rx_tick, held otherwise
//   rx_tick   out one-clk pulse at each bit centre
//   rx_active out high while a frame is being sampled
//   glitch    out one-clk pulse when a start edge is rejected as noise
//
// Build option:
//   UART_RX_VOTE_EN defined   : bit value = 2-of-3 vote of samples at
//                               oversample indices 7, 8 and 9.
//   UART_RX_VOTE_EN undefined : bit value = single sample at index 8.
//   Tick timing is identical in both builds.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int CLKS_PER_SAMPLE = 27,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_en,
  input  logic rx_pin,
  output logic rx_in,
  output logic rx_tick,
  output logic rx_active,
  output logic glitch
);

  // ---------------------------------------------------------------------
  // Pin synchroniser and edge detector
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_s_reg;
  logic                   rx_s;
  logic                   fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg   <= '1;
      prev_s_reg <= 1'b1;
    end else begin
      sync_reg   <= {sync_reg[SYNC_STAGES-2:0], rx_pin};
      prev_s_reg <= rx_s;
    end
  end

  assign rx_s = sync_reg[SYNC_STAGES-1];
  // Edge detection keeps running while disabled, so a line that is already
  // low when rx_en rises does not look like a fresh start edge.
  assign fall = prev_s_reg & ~rx_s;

  // ---------------------------------------------------------------------
  // State and timing counters
  // ---------------------------------------------------------------------
  rx_state_t  state_reg, state_next;
  logic [3:0] os_cnt_reg;
  logic [3:0] bit_cnt_reg, bit_cnt_next;
  logic       eval_reg;
  logic       rx_in_reg, rx_in_next;
  logic       rx_tick_reg, tick_next;
  logic       glitch_reg, glitch_next;
  logic       strobe;
  logic       frame_run;
  logic       vote;

  // Counters only run while a frame is in progress. Holding them clear in
  // IDLE means the first cycle of START_CHK starts from prescaler=0 and
  // os_cnt=0, i.e. the oversample phase is anchored to the detected edge.
  assign frame_run = rx_en && (state_reg != IDLE);

  uart_baud_gen #(
    .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
  ) u_baud_gen (
    .clk   (clk),
    .rst   (rst),
    .clr   (!frame_run),
    .strobe(strobe)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_cnt_reg <= '0;
      eval_reg   <= 1'b0;
    end else begin
      if (!frame_run) begin
        os_cnt_reg <= '0;
      end else if (strobe) begin
        os_cnt_reg <= os_cnt_reg + 4'd1;  // wraps 15 -> 0
      end
      // Last sample lands on the os_cnt=9 strobe; decide one clk later.
      eval_reg <= frame_run && strobe && (os_cnt_reg == VOTE_HI);
    end
  end

  // ---------------------------------------------------------------------
  // Bit sampling
  // ---------------------------------------------------------------------
`ifdef UART_RX_VOTE_EN
  logic [2:0] samp_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_reg <= '1;
    end else if (frame_run && strobe) begin
      case (os_cnt_reg)
        VOTE_LO:  samp_reg[0] <= rx_s;
        VOTE_MID: samp_reg[1] <= rx_s;
        VOTE_HI:  samp_reg[2] <= rx_s;
        default:  ;
      endcase
    end
  end

  assign vote = majority3(samp_reg);
`else
  logic samp_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_reg <= 1'b1;
    end else if (frame_run && strobe && (os_cnt_reg == VOTE_MID)) begin
      samp_reg <= rx_s;
    end
  end

  assign vote = samp_reg;
`endif

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      rx_in_reg   <= 1'b1;
      rx_tick_reg <= 1'b0;
      glitch_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      rx_in_reg   <= rx_in_next;
      rx_tick_reg <= tick_next;
      glitch_reg  <= glitch_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rx_in_next   = rx_in_reg;
    tick_next    = 1'b0;
    glitch_next  = 1'b0;

    if (!rx_en) begin
      // Disable wins over a pending evaluation: no tick, rx_in holds.
      state_next   = IDLE;
      bit_cnt_next = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          bit_cnt_next = '0;
          if (fall) begin
            state_next = START_CHK;
          end
        end

        START_CHK: begin
          if (eval_reg) begin
            if (!vote) begin
              tick_next    = 1'b1;
              rx_in_next   = 1'b0;
              bit_cnt_next = '0;
              state_next   = BIT;
            end else begin
              glitch_next = 1'b1;
              state_next  = IDLE;
            end
          end
        end

        BIT: begin
          if (eval_reg) begin
            tick_next    = 1'b1;
            rx_in_next   = vote;
            bit_cnt_next = bit_cnt_reg + 4'd1;
            // Stop bit is passed through as sampled; leave at its centre.
            if (bit_cnt_reg == STOP_IDX) begin
              state_next = IDLE;
            end
          end
        end

        default: begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end
      endcase
    end
  end

  assign rx_in     = rx_in_reg;
  assign rx_tick   = rx_tick_reg;
  assign glitch    = glitch_reg;
  assign rx_active = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler
//   Directed + randomised bench for uart_rx_sampler with CLKS_PER_SAMPLE=4
//   (64 clks per bit). The pin level of every clk is logged; expected tick
//   times and bit values are derived from that log using the sampling rule
//   (samples 32/36/40 clks into each bit after the pin edge, decision
//   reported 44 clks in). Ticks and glitches are captured by a monitor and
//   compared frame by frame.
module tb_uart_rx_sampler;

  localparam int CPS      = 4;
  localparam int SYNC     = 2;
  localparam int BIT_CLKS = 16 * CPS;
  localparam int FRAME    = 10 * BIT_CLKS;
  localparam int TICK_OFS = 44;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rx_en = 1'b0;
  logic rx_pin = 1'b1;
  logic rx_in, rx_tick, rx_active, glitch;

  uart_rx_sampler #(
    .CLKS_PER_SAMPLE(CPS),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_en    (rx_en),
    .rx_pin   (rx_pin),
    .rx_in    (rx_in),
    .rx_tick  (rx_tick),
    .rx_active(rx_active),
    .glitch   (glitch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit hist [0:65535];

  int checks = 0;
  int failures = 0;

  typedef struct {
    int   c;
    logic v;
  } tick_t;

  tick_t tq[$];
  int    gq[$];
  int    overlap_cnt = 0;
  int    double_cnt = 0;
  logic  prev_tick = 1'b0;
  logic  prev_gl = 1'b0;

  always @(negedge clk) begin
    tick_t t;
    if (rx_tick === 1'b1) begin
      t.c = cyc;
      t.v = rx_in;
      tq.push_back(t);
    end
    if (glitch === 1'b1) gq.push_back(cyc);
    if (rx_tick === 1'b1 && glitch === 1'b1) overlap_cnt <= overlap_cnt + 1;
    if ((rx_tick === 1'b1 && prev_tick) || (glitch === 1'b1 && prev_gl))
      double_cnt <= double_cnt + 1;
    prev_tick <= (rx_tick === 1'b1);
    prev_gl   <= (glitch === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // One clk of line level; called just after a rising edge.
  task automatic drive(input logic v);
    rx_pin = v;
    hist[cyc] = v;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1);
  endtask

  // Reference: bit value reported for tick n of a frame whose start edge
  // was driven at cycle s.
  function automatic logic exp_bit(input int s, input int n);
    logic a, b, c;
    a = hist[s + n * BIT_CLKS + 32];
    b = hist[s + n * BIT_CLKS + 36];
    c = hist[s + n * BIT_CLKS + 40];
`ifdef UART_RX_VOTE_EN
    return (a & b) | (a & c) | (b & c);
`else
    if (a || c) begin end
    return b;
`endif
  endfunction

  // Sends a full 640-clk frame. nrand random spikes land in data bits,
  // centre_n>=0 puts a 4-clk low spike over the middle sample of that bit,
  // drop_off>=0 drops rx_en at that offset.
  task automatic send_frame(input logic [7:0] data, input int nrand, input int centre_n,
                            input int drop_off, output int s);
    logic lvl [0:FRAME-1];
    for (int n = 0; n < 10; n++) begin
      logic bv;
      bv = (n == 0) ? 1'b0 : (n == 9) ? 1'b1 : data[n-1];
      for (int k = 0; k < BIT_CLKS; k++) lvl[n*BIT_CLKS + k] = bv;
    end
    for (int k = 0; k < nrand; k++) begin
      int n, off, w;
      n   = $urandom_range(8, 1);
      off = $urandom_range(50, 8);
      w   = $urandom_range(6, 1);
      for (int j = 0; j < w; j++) lvl[n*BIT_CLKS + off + j] = ~lvl[n*BIT_CLKS + off + j];
    end
    if (centre_n >= 0)
      for (int j = 34; j < 38; j++) lvl[centre_n*BIT_CLKS + j] = 1'b0;
    s = cyc;
    for (int i = 0; i < FRAME; i++) begin
      if (i == 300) check("active_mid", rx_active, 1);
      if (i == 630) check("active_end", rx_active, 0);
      if (i == drop_off) begin
        check("tick_at_drop", rx_tick, 1);
        rx_en = 1'b0;
      end
      if (drop_off >= 0 && i == drop_off + 1) check("active_after_drop", rx_active, 0);
      drive(lvl[i]);
    end
  endtask

  task automatic check_frame(input string tag, input int s, input int nexp);
    for (int i = 0; i < nexp; i++) begin
      tick_t t;
      if (tq.size() == 0) break;
      t = tq.pop_front();
      check({tag, "_time"}, t.c, s + TICK_OFS + i * BIT_CLKS);
      check({tag, "_val"}, t.v, exp_bit(s, i));
    end
  endtask

  initial begin
    int s, s2;
    logic [7:0] d;
    logic exp_spike;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_in", rx_in, 1);
    check("rst_tick", rx_tick, 0);
    check("rst_active", rx_active, 0);
    check("rst_glitch", glitch, 0);
    rst = 1'b1;
    rx_en = 1'b1;
    idle(20);

    // Clean 0xA5 frame
    send_frame(8'hA5, 0, -1, -1, s);
    check("a5_count", tq.size(), 10);
    check_frame("a5", s, 10);
    idle(10);

    // False start: 16-clk low pulse
    s = cyc;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) check("fs_active", rx_active, 1);
      drive(1'b0);
    end
    idle(60);
    check("fs_glitch_count", gq.size(), 1);
    if (gq.size() > 0) check("fs_glitch_time", gq[0], s + TICK_OFS);
    check("fs_ticks", tq.size(), 0);
    check("fs_active_end", rx_active, 0);
    gq.delete();

    // Centre spike on data bit 1 of 0xFF (tick index 2)
`ifdef UART_RX_VOTE_EN
    exp_spike = 1'b1;
`else
    exp_spike = 1'b0;
`endif
    send_frame(8'hFF, 0, 2, -1, s);
    check("spike_count", tq.size(), 10);
    if (tq.size() > 2) check("spike_val", tq[2].v, exp_spike);
    check_frame("spike", s, 10);
    idle(10);

    // Back-to-back 0x00 then 0xFF
    send_frame(8'h00, 0, -1, -1, s);
    send_frame(8'hFF, 0, -1, -1, s2);
    check("b2b_count", tq.size(), 20);
    check_frame("b2b1", s, 10);
    check_frame("b2b2", s2, 10);
    idle(10);

    // rx_en drop at the 5th tick
    d = 8'($urandom);
    send_frame(d, 0, -1, 4 * BIT_CLKS + TICK_OFS, s);
    check("drop_count", tq.size(), 5);
    check("drop_hold", rx_in, exp_bit(s, 4));
    check_frame("drop", s, 5);
    idle(20);
    rx_en = 1'b1;
    idle(20);
    d = 8'($urandom);
    send_frame(d, 0, -1, -1, s);
    check("reen_count", tq.size(), 10);
    check_frame("reen", s, 10);
    idle(10);

    // Reset during the 4th bit of a 0x00 frame
    s = cyc;
    for (int i = 0; i < 3 * BIT_CLKS + 50; i++) drive((i < BIT_CLKS * 9) ? 1'b0 : 1'b1);
    check("mid_pre_count", tq.size(), 4);
    check("mid_pre_rx_in", rx_in, 0);
    check_frame("mid_pre", s, 4);
    rst = 1'b0;
    #1;
    check("mid_rst_rx_in", rx_in, 1);
    check("mid_rst_active", rx_active, 0);
    check("mid_rst_tick", rx_tick, 0);
    check("mid_rst_glitch", glitch, 0);
    #1;
    rx_pin = 1'b1;
    hist[cyc] = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1);
    drive(1'b1);
    rst = 1'b1;
    idle(30);
    check("mid_no_ticks", tq.size(), 0);
    send_frame(8'h3C, 0, -1, -1, s);
    check("x3c_count", tq.size(), 10);
    check_frame("x3c", s, 10);
    idle(5);

    // Randomised frames with spikes and random gaps (gap 0 = back-to-back)
    for (int f = 0; f < 6; f++) begin
      idle($urandom_range(12, 0));
      d = 8'($urandom);
      send_frame(d, $urandom_range(3, 0), -1, -1, s);
      check("rnd_count", tq.size(), 10);
      check_frame("rnd", s, 10);
    end
    idle(20);

    check("glitch_spurious", gq.size(), 0);
    check("tick_glitch_overlap", overlap_cnt, 0);
    check("pulse_two_clks", double_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Receive front end that sits directly upstream of the UART receiver FSM.
- Synchronises the asynchronous serial pin to clk and detects the start-bit falling edge.
- Oversamples each bit 16x and emits one rx_tick pulse at each bit centre, with a voted bit value on rx_in.
- Each frame produces exactly 10 ticks: start, 8 data, stop. This matches the receiver's tick/data contract.

Parameters:
- CLKS_PER_SAMPLE, 27: clk cycles per oversample strobe (27 gives 50 MHz / 115200 / 16); minimum 2.
- OSR, 16: oversample strobes per bit; fixed, other values unsupported.
- SYNC_STAGES, 2: flip-flop depth of the pin synchroniser; minimum 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_en  in  1  sampler enable; low forces IDLE and suppresses ticks
- rx_pin  in  1  raw asynchronous serial line, idle high
- rx_in  out  1  registered voted bit value; valid when rx_tick=1, held between ticks
- rx_tick  out  1  one-clk pulse at each bit centre
- rx_active  out  1  high while a frame is being sampled (START_CHK or BIT)
- glitch  out  1  one-clk pulse when a start edge is rejected as noise

Behaviour:
- Reset values (rst=0, asynchronous):
  - synchroniser chain all 1, state IDLE, prescaler=0, os_cnt=0, bit_cnt=0
  - rx_in=1, rx_tick=0, rx_active=0, glitch=0
- Synchroniser: rx_pin passes through SYNC_STAGES flip-flops to give rx_s; prev_s is rx_s delayed by one clk.
- Falling edge: prev_s=1 and rx_s=0. Pin-to-edge latency is SYNC_STAGES+1 clks.
- Prescaler:
  - counts 0..CLKS_PER_SAMPLE-1 and wraps
  - strobe = prescaler==CLKS_PER_SAMPLE-1
  - cleared in IDLE and on edge detect, so strobe phase is anchored to the edge
- os_cnt: 4-bit counter that advances on each strobe and wraps 15 to 0. It is cleared on edge detect.
- Vote register: captures rx_s on strobes where os_cnt is 7, 8 or 9.
- Evaluation point: the clk after the strobe at os_cnt=9. Here vote = majority of the 3 samples.
- States:
  - IDLE: rx_active=0. A falling edge with rx_en=1 moves to START_CHK.
  - START_CHK: at the evaluation point:
    - vote=0: rx_tick=1 and rx_in=0; bit_cnt=0; go to BIT.
    - vote=1: glitch=1, no tick; go to IDLE.
  - BIT: each evaluation point sets rx_tick=1 and rx_in=vote, then bit_cnt+1.
    - After the 9th BIT tick (the stop bit, bit_cnt==8 before increment), go to IDLE.
    - No ticks are produced until the next falling edge.
- Stop handling:
  - The sampler returns to IDLE at mid-stop-bit, so back-to-back frames are not missed.
  - A low stop-bit value is passed through unchanged; framing judgement belongs to the downstream receiver.
- rx_tick and glitch never assert in the same cycle, and are never high for two consecutive clks.
- Ticks within one frame are exactly OSR*CLKS_PER_SAMPLE clks apart.
- rx_en=0 in any state: go to IDLE on the next clk, no further ticks, counters cleared, rx_in holds its last value.
- rx_en rising mid-line: nothing happens until a fresh falling edge. A line already low is ignored until it returns high.
- A falling edge during START_CHK or BIT is ignored. Only IDLE arms on an edge.
- Reset mid-frame: immediate return to reset values, no partial tick.

Optional Feature:
- Macro: UART_RX_VOTE_EN
- Defined: 3-sample majority vote at os_cnt 7/8/9, as described above.
- Undefined: a single sample at os_cnt=8 is used as the vote. Evaluation point and tick timing are unchanged (still the clk after the os_cnt=9 strobe).

Decomposition:
- Package uart_pkg holds:
  - state typedef (IDLE, START_CHK, BIT)
  - OSR=16
  - VOTE_LO=7, VOTE_MID=8, VOTE_HI=9
  - FRAME_TICKS=10
- Sub-module uart_baud_gen: the prescaler with synchronous clear and strobe output. The synchroniser and FSM stay in the top module.

Test Plan:
- Setup: CLKS_PER_SAMPLE=4, so 1 bit = 64 clks.
- Clean frame: 0xA5 sent LSB-first with a clean stop bit.
  - Expect 10 ticks spaced 64 clks apart.
  - rx_in at the ticks = 0,1,0,1,0,0,1,0,1,1.
  - rx_active spans start to stop tick; glitch never asserts.
- False start: a 16-clk low pulse on an idle line.
  - Expect glitch=1 for 1 clk about 40 clks after the edge, no rx_tick, return to IDLE.
- Centre spike with UART_RX_VOTE_EN:
  - A 4-clk low spike centred on os_cnt=8 of a 1 data bit must give rx_in=1 at that tick.
  - Without the macro it must give rx_in=0.
- Back-to-back frames: 0x00 then 0xFF with no idle gap.
  - Expect 20 ticks with correct values and second-frame tick timing re-anchored to its own start edge.
- rx_en drop: deassert at the 5th tick.
  - Expect no further ticks and rx_active=0 the next clk.
  - After re-enable, a new frame samples correctly.
- Reset mid-frame: drive rst=0 for 3 clks at the 4th bit.
  - Outputs go to reset values asynchronously.
  - A subsequent 0x3C frame gives rx_in at the ticks = 0,0,0,1,1,1,1,0,0,1.
